// File: rtl/dom_and_pipe.sv
// -----------------------------------------------------------------------------
// dom_and_pipe
//   Pipelined domain-oriented-masking (DOM-indep) AND gadget over SHARES shares
//   of WIDTH bits each.  Computes q = a & b share-wise without ever combining
//   cross-domain products before they are resharded and registered.
//
//   Stage 1 registers every product term:
//     term[i][i] = a_i & b_i                      (inner, same domain)
//     term[i][j] = (a_i & b_j) ^ r_{min,max}      (cross, resharded)
//   Stage 2 (output register) folds each row: q_i = XOR_j term[i][j].
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   in_valid     operand shares valid
//   in_ready     gadget can accept operands (registered state + out_ready)
//   a_sh, b_sh   operand shares, share i at [i*WIDTH +: WIDTH]
//   rand_in      fresh randomness, pair (i<j) lexicographic index k
//                at [k*WIDTH +: WIDTH]
//   rand_valid   rand_in is fresh this cycle (required for accept)
//   out_valid    q_sh valid
//   out_ready    downstream accepts q_sh
//   q_sh         output shares, same packing as a_sh
//   starve_cnt   saturating count of cycles offered but blocked for lack
//                of randomness
//
// Build option
//   DOM_CLEAR_EN  when defined, a stage that empties with nothing entering
//                 has its data registers zeroed in the same cycle.
// -----------------------------------------------------------------------------
module dom_and_pipe #(
    parameter int WIDTH  = 4,
    parameter int SHARES = 2,
    parameter int NRAND  = SHARES * (SHARES - 1) / 2 * WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SHARES*WIDTH-1:0]   a_sh,
    input  logic [SHARES*WIDTH-1:0]   b_sh,
    input  logic [NRAND-1:0]          rand_in,
    input  logic                      rand_valid,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SHARES*WIDTH-1:0]   q_sh,
    output logic [15:0]               starve_cnt
);

    generate
        if (SHARES < 2 || SHARES > 4) begin : g_bad_shares
            $error("dom_and_pipe: SHARES must be 2..4");
        end
        if (NRAND != SHARES * (SHARES - 1) / 2 * WIDTH) begin : g_bad_nrand
            $error("dom_and_pipe: NRAND must not be overridden");
        end
    endgenerate

    localparam int unsigned NS = SHARES;
    localparam int unsigned NT = SHARES * SHARES;

    // Lexicographic index of pair (lo, hi), lo < hi, in the randomness bus.
    function automatic int unsigned pair_idx(input int unsigned lo, input int unsigned hi);
        return lo * (2 * NS - lo - 1) / 2 + (hi - lo - 1);
    endfunction

    logic                    s1_valid;
    logic [WIDTH-1:0]        s1_term   [NT];
    logic [WIDTH-1:0]        term_next [NT];
    logic [SHARES*WIDTH-1:0] q_next;
    logic                    accept;
    logic                    s2_load;
    logic                    starve;

    assign in_ready = !s1_valid || !out_valid || out_ready;
    assign accept   = in_valid && rand_valid && in_ready;
    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign starve   = in_valid && !rand_valid && in_ready;

    // Diagonal holds the inner product so each output row is a plain XOR
    // over one row of registered terms.
    always_comb begin
        for (int unsigned k = 0; k < NT; k++) begin
            term_next[k] = '0;
        end
        for (int unsigned i = 0; i < NS; i++) begin
            for (int unsigned j = 0; j < NS; j++) begin
                if (i == j) begin
                    term_next[i*NS + j] = a_sh[i*WIDTH +: WIDTH] & b_sh[i*WIDTH +: WIDTH];
                end else begin
                    term_next[i*NS + j] = (a_sh[i*WIDTH +: WIDTH] & b_sh[j*WIDTH +: WIDTH])
                        ^ rand_in[pair_idx((i < j) ? i : j, (i < j) ? j : i)*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_comb begin
        q_next = '0;
        for (int unsigned i = 0; i < NS; i++) begin
            for (int unsigned j = 0; j < NS; j++) begin
                q_next[i*WIDTH +: WIDTH] = q_next[i*WIDTH +: WIDTH] ^ s1_term[i*NS + j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            for (int unsigned k = 0; k < NT; k++) begin
                s1_term[k] <= '0;
            end
            out_valid  <= 1'b0;
            q_sh       <= '0;
            starve_cnt <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                for (int unsigned k = 0; k < NT; k++) begin
                    s1_term[k] <= term_next[k];
                end
            end else if (s2_load) begin
                s1_valid <= 1'b0;
`ifdef DOM_CLEAR_EN
                for (int unsigned k = 0; k < NT; k++) begin
                    s1_term[k] <= '0;
                end
`endif
            end

            if (s2_load) begin
                out_valid <= 1'b1;
                q_sh      <= q_next;
            end else if (out_ready) begin
                out_valid <= 1'b0;
`ifdef DOM_CLEAR_EN
                if (out_valid) begin
                    q_sh <= '0;
                end
`endif
            end

            if (starve && (starve_cnt != 16'hFFFF)) begin
                starve_cnt <= starve_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_dom_and_pipe.sv
// -----------------------------------------------------------------------------
// tb_dom_and_pipe
//   Directed bench for dom_and_pipe: a 2-share/4-bit instance for hand-checked
//   vectors, stall, starvation and reset, and a 3-share/8-bit instance driven
//   with random operands and handshakes. Unmasked results (XOR of output
//   shares) are checked against a & b computed from the operand shares.
// -----------------------------------------------------------------------------
module tb_dom_and_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // 2 shares x 4 bits
    logic        iv2, ir2, rv2, ov2, or2;
    logic [7:0]  a2, b2, q2;
    logic [3:0]  r2;
    logic [15:0] sc2;

    dom_and_pipe #(.WIDTH(4), .SHARES(2)) u2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2),
        .a_sh(a2), .b_sh(b2), .rand_in(r2), .rand_valid(rv2),
        .out_valid(ov2), .out_ready(or2), .q_sh(q2), .starve_cnt(sc2)
    );

    // 3 shares x 8 bits
    logic        iv3, ir3, rv3, ov3, or3;
    logic [23:0] a3, b3, q3, r3;
    logic [15:0] sc3;

    dom_and_pipe #(.WIDTH(8), .SHARES(3)) u3 (
        .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3),
        .a_sh(a3), .b_sh(b3), .rand_in(r3), .rand_valid(rv3),
        .out_valid(ov3), .out_ready(or3), .q_sh(q3), .starve_cnt(sc3)
    );

    // Scoreboards: push unmasked a & b on accept, compare on each drain.
    logic [3:0] exp2 [$];
    logic [7:0] exp3 [$];
    int n_out2 = 0;
    int n_out3 = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp2.delete();
            exp3.delete();
        end else begin
            if (ov2 && or2) begin
                if (exp2.size() == 0) check("u2_spurious_out", 1, 0);
                else check("u2_xor", {60'd0, q2[3:0] ^ q2[7:4]}, {60'd0, exp2.pop_front()});
                n_out2++;
            end
            if (iv2 && rv2 && ir2)
                exp2.push_back((a2[3:0] ^ a2[7:4]) & (b2[3:0] ^ b2[7:4]));
            if (ov3 && or3) begin
                if (exp3.size() == 0) check("u3_spurious_out", 1, 0);
                else check("u3_xor", {56'd0, q3[7:0] ^ q3[15:8] ^ q3[23:16]}, {56'd0, exp3.pop_front()});
                n_out3++;
            end
            if (iv3 && rv3 && ir3)
                exp3.push_back((a3[7:0] ^ a3[15:8] ^ a3[23:16]) & (b3[7:0] ^ b3[15:8] ^ b3[23:16]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int base;
    int cyc;

    initial begin
        rst = 1'b1;
        iv2 = 0; rv2 = 0; or2 = 0; a2 = '0; b2 = '0; r2 = '0;
        iv3 = 0; rv3 = 0; or3 = 0; a3 = '0; b3 = '0; r3 = '0;
        repeat (3) tick();
        check("rst_ov", ov2, 0);
        check("rst_q", q2, 0);
        check("rst_sc", sc2, 0);
        check("rst_ir", ir2, 1);
        rst = 1'b0;
        tick();

        // Hand vector: a={9,3}, b={9,5}, r=6 -> q0=6, q1=E
        a2 = 8'h93; b2 = 8'h95; r2 = 4'h6; iv2 = 1; rv2 = 1; or2 = 1;
        tick();
        iv2 = 0;
        check("lat_ov_early", ov2, 0);
        tick();
        check("lat_ov", ov2, 1);
        check("vec_q", q2, 8'hE6);
        tick();
        check("vec_drained", ov2, 0);

        // Back-to-back, one result per cycle
        base = n_out2;
        for (int i = 0; i < 8; i++) begin
            a2 = 8'($urandom); b2 = 8'($urandom); r2 = 4'($urandom);
            iv2 = 1; rv2 = 1; or2 = 1;
            #1;
            check("b2b_ready", ir2, 1);
            check("b2b_ov", ov2, (i >= 2) ? 1 : 0);
            tick();
        end
        iv2 = 0;
        repeat (3) tick();
        check("b2b_count", n_out2 - base, 8);

        // Stall: A then B accepted, then blocked
        or2 = 0; iv2 = 1; rv2 = 1;
        a2 = 8'h93; b2 = 8'h95; r2 = 4'h6;
        tick();
        check("stall_ir_one", ir2, 1);
        a2 = 8'hF0; b2 = 8'h0F; r2 = 4'h5;   // q = {A,5}
        tick();
        check("stall_ir_full", ir2, 0);
        check("stall_ov", ov2, 1);
        a2 = 8'h3C; b2 = 8'h5A; r2 = 4'h9;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold_q", q2, 8'hE6);
            check("stall_hold_ir", ir2, 0);
        end
        base = n_out2;
        or2 = 1;
        #1;
        check("release_ir", ir2, 1);
        tick();
        iv2 = 0;
        check("release_q_b", q2, 8'hA5);
        tick();
        check("release_ov_c", ov2, 1);
        tick();
        check("release_empty", ov2, 0);
        check("release_count", n_out2 - base, 3);

        // Starvation
        iv2 = 1; rv2 = 0;
        repeat (5) tick();
        check("starve_5", sc2, 5);
        check("starve_no_accept", ov2, 0);
        repeat (65535) @(posedge clk);
        #1;
        check("starve_sat", sc2, 16'hFFFF);
        repeat (2) tick();
        check("starve_sat_hold", sc2, 16'hFFFF);

        // Reset with both stages full
        or2 = 0; rv2 = 1; iv2 = 1;
        repeat (2) tick();
        check("prerst_full", ir2, 0);
        rst = 1;
        tick();
        rst = 0; iv2 = 0;
        check("midrst_ov", ov2, 0);
        check("midrst_q", q2, 0);
        check("midrst_sc", sc2, 0);
        check("midrst_ir", ir2, 1);
        or2 = 1;
        repeat (3) tick();
        check("midrst_discard", ov2, 0);

        // 3 shares, random operands and handshakes
        cyc = 0;
        while (n_out3 < 1000 && cyc < 20000) begin
            a3 = 24'($urandom); b3 = 24'($urandom); r3 = 24'($urandom);
            iv3 = ($urandom_range(0, 3) != 0);
            rv3 = ($urandom_range(0, 4) != 0);
            or3 = ($urandom_range(0, 3) != 0);
            tick();
            cyc++;
        end
        check("u3_done", (n_out3 >= 1000) ? 1 : 0, 1);
        iv3 = 0; or3 = 1;
        cyc = 0;
        while ((ov3 || exp3.size() != 0) && cyc < 20) begin
            tick();
            cyc++;
        end
        check("u3_drain", (exp3.size() == 0 && !ov3) ? 1 : 0, 1);
`ifdef DOM_CLEAR_EN
        check("u3_clear_q", q3, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
